// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: PC/word widths, fetch FSM states, queue entry layout.
package cpu_pkg;

   localparam int PC_W    = 8;
   localparam int WORD_W  = 32;
   localparam int IMEM_AW = 6;
   localparam int PC_STEP = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [PC_W-1:0]   pc;
   } queue_entry_t;

   localparam int ENTRY_W = $bits(queue_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mem_we;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_we   = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we = push;
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read once count covers it.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: byte PC, credit-limited word reads, in-order prefetch queue, redirect flush.
// Optional FETCH_STATS_EN adds saturating stat_fetched / stat_flushed counters.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter int              MAX_OUT  = 2,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_rvalid,
   input  logic [WORD_W-1:0]  imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [WORD_W-1:0]  instr_word,
   output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]        stat_fetched,
   output logic [15:0]        stat_flushed
`endif
);

   localparam int               CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]   stale_q, stale_d;
   logic [CNT_W-1:0]   outstanding, q_count, remaining, stale_after;
   logic [PC_W-1:0]    tag_head;
   logic [ENTRY_W-1:0] q_head_raw;
   queue_entry_t       q_head, q_push_entry;
   logic               credit, rsp_live, rsp_stale, handshake;

   // The PC-tag FIFO holds one entry per read in flight, so its count is the outstanding count.
   fetch_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (imem_req),
      .push_data (pc_q),
      .pop       (rsp_live),
      .flush     (redirect_valid),
      .head_data (tag_head),
      .count     (outstanding)
   );

   fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_instr_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_live),
      .push_data (q_push_entry),
      .pop       (handshake),
      .flush     (redirect_valid),
      .head_data (q_head_raw),
      .count     (q_count)
   );

   assign q_push_entry = '{word: imem_rdata, pc: tag_head};
   assign q_head       = queue_entry_t'(q_head_raw);

   assign credit      = (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C) && (outstanding < MAX_OUT_C);
   assign rsp_live    = imem_rvalid && (stale_q == '0);
   assign rsp_stale   = imem_rvalid && (stale_q != '0);
   assign instr_valid = (q_count != '0);
   assign handshake   = instr_valid && instr_ready;
   assign imem_req    = (state_q == FETCH) && credit && !redirect_valid;
   assign imem_addr   = pc_q[PC_W-1:2];
   assign instr_word  = instr_valid ? q_head.word : '0;
   assign instr_pc    = instr_valid ? q_head.pc : '0;

   // Reads still owed after this cycle's response; on a redirect they all turn stale.
   assign remaining   = outstanding - CNT_W'(rsp_live);
   assign stale_after = stale_q - CNT_W'(rsp_stale);

   always_comb begin
      state_d = state_q;
      pc_d    = imem_req ? pc_q + PC_W'(PC_STEP) : pc_q;
      stale_d = stale_after;
      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (!credit) state_d = HOLD;
         HOLD:    if (credit) state_d = FETCH;
         DRAIN:   if (stale_after == '0) state_d = FETCH;
         default: state_d = IDLE;
      endcase
      if (redirect_valid) begin
         pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
         stale_d = stale_after + remaining;
         state_d = (stale_d != '0) ? DRAIN : FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         stale_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stale_q <= stale_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [15:0] fetched_q, fetched_d;
   logic [15:0] flushed_q, flushed_d;
   logic [16:0] flush_sum;

   // A word handshaked in the redirect cycle belongs to decode and is not counted as flushed.
   always_comb begin
      fetched_d = fetched_q;
      flushed_d = flushed_q;
      flush_sum = {1'b0, flushed_q} + 17'(q_count) - 17'(handshake) + 17'(outstanding);
      if (handshake && (fetched_q != 16'hFFFF)) fetched_d = fetched_q + 16'd1;
      if (redirect_valid) flushed_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetched_q <= '0;
         flushed_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         flushed_q <= flushed_d;
      end
   end

   assign stat_fetched = fetched_q;
   assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural in-order imem with variable latency,
// scoreboard of expected delivery PCs, request-address model and stale-drain checking.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [5:0]  imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_word;
   logic [7:0]  instr_pc;
`ifdef FETCH_STATS_EN
   logic [15:0] stat_fetched;
   logic [15:0] stat_flushed;
`endif

   fetch_unit #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_word     (instr_word),
      .instr_pc       (instr_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_flushed   (stat_flushed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] addr;
      int         due;
      int         epoch;
   } txn_t;

   txn_t       pend[$];
   logic [7:0] exp_pc_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         lat = 1;
   int         cur_epoch = 0;
   int         req_cnt = 0;
   int         deliv_cnt = 0;
   logic [7:0] exp_req_pc = 8'h00;

   function automatic logic [31:0] word_of(input logic [5:0] a);
      return {16'hC0DE, 10'h000, a};
   endfunction

   function automatic int old_pending();
      int n = 0;
      foreach (pend[i]) if (pend[i].epoch != cur_epoch) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_seq(input logic [7:0] start, input int n);
      for (int i = 0; i < n; i++) exp_pc_q.push_back(start + 8'(4 * i));
   endtask

   task automatic do_redirect(input logic [7:0] target);
      logic [7:0] aligned;
      aligned        = {target[7:2], 2'b00};
      redirect_valid = 1'b1;
      redirect_pc    = target;
      cur_epoch++;
      exp_req_pc     = aligned;
      tick(1);
      redirect_valid = 1'b0;
      exp_pc_q.delete();
      push_seq(aligned, 64);
   endtask

   // Instruction memory: in-order responses, fixed latency sampled per request.
   initial begin
      logic       s_req;
      logic       s_rst;
      logic [5:0] s_addr;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         s_req  = imem_req;
         s_addr = imem_addr;
         s_rst  = rst;
         if (!rst && imem_req) begin
            check("req_addr", 32'(imem_addr), 32'(exp_req_pc[7:2]));
            check("req_while_stale", 32'(old_pending()), 32'd0);
            exp_req_pc = exp_req_pc + 8'd4;
         end
         @(posedge clk);
         cyc++;
         if (s_rst) begin
            pend.delete();
         end else begin
            if (imem_rvalid) void'(pend.pop_front());
            if (s_req) begin
               pend.push_back('{addr: s_addr, due: cyc + lat - 1, epoch: cur_epoch});
               req_cnt++;
            end
         end
         #1;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend[0].addr);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end
      end
   end

   // Scoreboard: every handshake pops the next expected PC.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && instr_valid && instr_ready) begin
            deliv_cnt++;
            check("sb_nonempty", 32'(exp_pc_q.size() != 0), 32'd1);
            if (exp_pc_q.size() != 0) begin
               e = exp_pc_q.pop_front();
               check("instr_pc", 32'(instr_pc), 32'(e));
               check("instr_word", instr_word, word_of(e[7:2]));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int r0;
      int queued;
      int exp_flushed;
      logic found;

      rst            = 1'b1;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      lat            = 1;
      tick(2);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr_word", instr_word, 32'd0);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);

      // Streaming from reset with 1-cycle imem.
      exp_req_pc  = 8'h00;
      push_seq(8'h00, 64);
      instr_ready = 1'b1;
      rst         = 1'b0;
      tick(1);
      check("first_fetch_req", 32'(imem_req), 32'd1);
      check("valid_c1", 32'(instr_valid), 32'd0);
      tick(1);
      check("valid_c2", 32'(instr_valid), 32'd0);
      tick(1);
      check("valid_c3", 32'(instr_valid), 32'd1);
      check("pc_c3", 32'(instr_pc), 32'h00);
      tick(1);
      check("pc_c4", 32'(instr_pc), 32'h04);
      tick(1);
      check("pc_c5", 32'(instr_pc), 32'h08);

      // Stall: requests stop once queue plus outstanding reach DEPTH.
      instr_ready = 1'b0;
      tick(12);
      check("stall_req_off", 32'(imem_req), 32'd0);
      check("stall_queued", 32'(req_cnt - deliv_cnt), 32'd4);
      check("stall_outstanding", 32'(pend.size()), 32'd0);
      check("stall_valid", 32'(instr_valid), 32'd1);
      instr_ready = 1'b1;
      tick(10);

      // Redirect near the top of the address space; low PC bits are ignored.
      do_redirect(8'hFB);
      check("wrap_redir_valid", 32'(instr_valid), 32'd0);
      d0 = deliv_cnt;
      tick(12);
      check("wrap_progress", 32'(deliv_cnt - d0 >= 4), 32'd1);

      // Redirect with two reads outstanding on a 3-cycle imem.
      lat = 3;
      tick(8);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (pend.size() == 2 && !imem_rvalid) found = 1'b1;
         else tick(1);
      end
      check("wait_two_out", 32'(found), 32'd1);
      do_redirect(8'h40);
      check("drain_redir_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 40 && !instr_valid; i++) tick(1);
      check("drain_first_pc", 32'(instr_pc), 32'h40);
      tick(6);

      // Redirect in the same cycle as a handshake and a response.
      lat = 1;
      tick(10);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid && imem_rvalid) found = 1'b1;
         else tick(1);
      end
      check("wait_hs_rsp", 32'(found), 32'd1);
      d0 = deliv_cnt;
      do_redirect(8'h80);
      check("redir_hs_delivered", 32'(deliv_cnt - d0), 32'd1);
      check("redir_hs_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 20 && !instr_valid; i++) tick(1);
      check("redir_hs_first_pc", 32'(instr_pc), 32'h80);
      tick(4);

      // Reset mid-stream, deliver five words, then flush a partly full pipe.
      rst = 1'b1;
      tick(2);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_req", 32'(imem_req), 32'd0);
      exp_pc_q.delete();
      push_seq(8'h00, 64);
      exp_req_pc  = 8'h00;
      instr_ready = 1'b0;
      d0          = deliv_cnt;
      r0          = req_cnt;
      rst         = 1'b0;
      tick(8);
      instr_ready = 1'b1;
      tick(5);
      instr_ready = 1'b0;
      check("five_delivered", 32'(deliv_cnt - d0), 32'd5);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         queued = (req_cnt - r0) - (deliv_cnt - d0) - pend.size();
         if (queued == 2 && pend.size() == 1) found = 1'b1;
         else tick(1);
      end
      check("wait_two_one", 32'(found), 32'd1);
      queued      = (req_cnt - r0) - (deliv_cnt - d0) - pend.size();
      exp_flushed = queued + pend.size();
      do_redirect(8'h20);
      check("stats_redir_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_STATS_EN
      check("stat_fetched", 32'(stat_fetched), 32'(deliv_cnt - d0));
      check("stat_flushed", 32'(stat_flushed), 32'(exp_flushed));
`endif
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && !instr_valid; i++) tick(1);
      check("post_flush_pc", 32'(instr_pc), 32'h20);
      tick(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
